wave_synth_dds: RTL

- Direct-digital waveform generator for the scope/signal path: it produces 8-bit waveform samples at a frequency given as six BCD digits (units..lac, 0–999999 Hz).
- It is the source side of the frequency-measurement path. Its data_out feeds the same 8-bit sample bus that the threshold-based frequency counter consumes, so the pair can be tested end-to-end.
- BCD is converted to a 32-bit phase-accumulator tuning word by a sequential BCD-to-binary stage followed by a shift-add constant multiply.

---
 rtl/wave_synth_dds_if.sv | 30 +++
 rtl/wave_synth_dds.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/wave_synth_dds_if.sv
// Control/sample bus of the DDS waveform generator.
// freq_load is a one-cycle request taken only in a cycle where busy is low; requests seen while busy is high are dropped.
interface wave_synth_dds_if;
   logic [3:0]  fre_num_u;
   logic [3:0]  fre_num_d;
   logic [3:0]  fre_num_h;
   logic [3:0]  fre_num_t;
   logic [3:0]  fre_num_m;
   logic [3:0]  fre_num_l;
   logic        freq_load;
   logic [1:0]  wave_sel;
   logic [7:0]  data_out;
   logic        sync;
   logic        busy;
   logic        bcd_err;
   logic [31:0] tw_out;
   logic [2:0]  dbg_state;

   modport master (
      output fre_num_u, fre_num_d, fre_num_h, fre_num_t, fre_num_m, fre_num_l,
      output freq_load, wave_sel,
      input  data_out, sync, busy, bcd_err, tw_out, dbg_state
   );

   modport slave (
      input  fre_num_u, fre_num_d, fre_num_h, fre_num_t, fre_num_m, fre_num_l,
      input  freq_load, wave_sel,
      output data_out, sync, busy, bcd_err, tw_out, dbg_state
   );
endinterface

// File: rtl/wave_synth_dds.sv
// DDS waveform generator: six BCD digits -> 32-bit tuning word (BCD-to-binary, shift-add
// multiply), phase accumulator and registered square/saw/triangle/DC sample output.
module wave_synth_dds #(
   parameter int unsigned TW_K                = 11258999,
   parameter int unsigned TW_SHIFT            = 18,
   parameter bit          PHASE_RESET_ON_LOAD = 1'b1
) (
   input  logic             clk100,
   input  logic             rst,
   wave_synth_dds_if.slave  bus
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_CHECK   = 3'd1,
      S_BCD2BIN = 3'd2,
      S_MUL     = 3'd3,
      S_APPLY   = 3'd4
   } state_t;

   localparam logic [44:0] TW_K45 = 45'(TW_K);

   state_t          state_q, state_d;
   logic [5:0][3:0] dig_q;
   logic [4:0]      cnt_q;
   logic [19:0]     f_q;
   logic [44:0]     mcand_q;
   logic [44:0]     product_q;
   logic [31:0]     tw_q;
   logic [31:0]     phase_q;
   logic            sync_q;
   logic            bcd_err_q;
   logic [7:0]      data_q;
   logic            digit_bad;
   logic [19:0]     f_times10;
   logic [32:0]     phase_sum;
   logic [7:0]      wave_d;

   always_comb begin
      digit_bad = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (dig_q[i] > 4'd9) digit_bad = 1'b1;
      end
   end

   // dig_q[0] holds the lac digit, so the conversion walks indices 0..5 MSD first.
   assign f_times10 = {f_q[16:0], 3'b000} + {f_q[18:0], 1'b0} + {16'd0, dig_q[cnt_q[2:0]]};

   always_ff @(posedge clk100 or negedge rst) begin
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (bus.freq_load) state_d = S_CHECK;
         S_CHECK:   state_d = digit_bad ? S_IDLE : S_BCD2BIN;
         S_BCD2BIN: if (cnt_q == 5'd5) state_d = S_MUL;
         S_MUL:     if (cnt_q == 5'd19) state_d = S_APPLY;
         S_APPLY:   state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk100 or negedge rst) begin
      if (!rst) begin
         dig_q     <= '0;
         cnt_q     <= '0;
         f_q       <= '0;
         mcand_q   <= '0;
         product_q <= '0;
         tw_q      <= '0;
         bcd_err_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.freq_load) begin
                  dig_q <= {bus.fre_num_u, bus.fre_num_d, bus.fre_num_h,
                            bus.fre_num_t, bus.fre_num_m, bus.fre_num_l};
               end
            end
            S_CHECK: begin
               if (digit_bad) begin
                  bcd_err_q <= 1'b1;
               end else begin
                  bcd_err_q <= 1'b0;
                  f_q       <= '0;
                  cnt_q     <= '0;
               end
            end
            S_BCD2BIN: begin
               f_q <= f_times10;
               if (cnt_q == 5'd5) begin
                  cnt_q     <= '0;
                  product_q <= '0;
                  mcand_q   <= TW_K45;
               end else begin
                  cnt_q <= cnt_q + 5'd1;
               end
            end
            S_MUL: begin
               // f is consumed LSB first; the multiplicand doubles alongside it.
               if (f_q[0]) product_q <= product_q + mcand_q;
               f_q     <= f_q >> 1;
               mcand_q <= mcand_q << 1;
               cnt_q   <= (cnt_q == 5'd19) ? 5'd0 : cnt_q + 5'd1;
            end
            S_APPLY: begin
               tw_q <= 32'(product_q >> TW_SHIFT);
            end
            default: ;
         endcase
      end
   end

   assign phase_sum = {1'b0, phase_q} + {1'b0, tw_q};

   always_ff @(posedge clk100 or negedge rst) begin
      if (!rst) begin
         phase_q <= '0;
         sync_q  <= 1'b0;
      end else if (PHASE_RESET_ON_LOAD && state_q == S_APPLY) begin
         phase_q <= '0;
         sync_q  <= 1'b0;
      end else begin
         phase_q <= phase_sum[31:0];
         sync_q  <= phase_sum[32];
      end
   end

   always_comb begin
      wave_d = 8'h00;
      case (bus.wave_sel)
         2'b00:   wave_d = phase_q[31] ? 8'h00 : 8'hFF;
         2'b01:   wave_d = phase_q[31:24];
         2'b10:   wave_d = phase_q[31] ? ~phase_q[30:23] : phase_q[30:23];
         default: wave_d = 8'h80;
      endcase
   end

   always_ff @(posedge clk100 or negedge rst) begin
      if (!rst) data_q <= 8'h00;
      else      data_q <= wave_d;
   end

   assign bus.data_out  = data_q;
   assign bus.sync      = sync_q;
   assign bus.busy      = (state_q != S_IDLE);
   assign bus.bcd_err   = bcd_err_q;
   assign bus.tw_out    = tw_q;
   assign bus.dbg_state = state_q;

endmodule
